// File: rtl/fft_result_viewer.sv
// rtl/fft_result_viewer.sv - FFT result store viewer; optional auto-step via FFT_VIEWER_AUTOSCAN_EN
// Steps the Inspect address with debounced buttons, captures Result after READ_LATENCY and scans it as hex.
module fft_result_viewer #(
  parameter int REFRESH_DIV     = 50000,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int READ_LATENCY    = 2
`ifdef FFT_VIEWER_AUTOSCAN_EN
  , parameter int AUTOSCAN_PERIOD = 25000000
`endif
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ActivateSSD,
  input  logic        Ready,
  input  logic [15:0] Result,
  input  logic        BtnNext,
  input  logic        BtnPrev,
  output logic [7:0]  Inspect,
  output logic [3:0]  Anode,
  output logic [6:0]  Segments,
  output logic        Dp,
  output logic        Valid
);

  localparam logic [15:0] REFRESH_LAST  = 16'(REFRESH_DIV - 1);
  localparam logic [19:0] DEBOUNCE_LAST = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]  LAT_LOAD      = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {ST_OFF, ST_REQ, ST_SHOW} state_t;

  state_t      state;
  logic [2:0]  lat_cnt;
  logic [15:0] disp;
  logic [15:0] refresh_cnt;
  logic [1:0]  slot;

  logic [1:0]  sync1, sync2, accepted;
  logic [19:0] db_cnt [2];
  logic [1:0]  btn_step;

  logic        do_step;
  logic [7:0]  step_addr;
  logic        capture;
  logic [15:0] disp_nxt;
  logic [15:0] refresh_nxt;
  logic [1:0]  slot_nxt;
  logic        auto_fire;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // bit 0 = Next, bit 1 = Prev; a step pulse fires on the cycle a high level is accepted
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1     <= 2'b00;
      sync2     <= 2'b00;
      accepted  <= 2'b00;
      btn_step  <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= {BtnPrev, BtnNext};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        btn_step[i] <= 1'b0;
        if (sync2[i] == accepted[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DEBOUNCE_LAST) begin
          db_cnt[i]   <= '0;
          accepted[i] <= sync2[i];
          btn_step[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 20'd1;
        end
      end
    end
  end

  always_comb begin
    do_step   = btn_step[0] ^ btn_step[1];
    step_addr = btn_step[0] ? Inspect + 8'd1 : Inspect - 8'd1;
    capture   = (state == ST_REQ) && !do_step && (lat_cnt == 3'd0);
    disp_nxt  = capture ? Result : disp;
  end

  // OFF parks the scan so the first lit digit after enabling is always digit 0
  always_comb begin
    refresh_nxt = refresh_cnt + 16'd1;
    slot_nxt    = slot;
    if (state == ST_OFF) begin
      refresh_nxt = '0;
      slot_nxt    = 2'd0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_nxt = '0;
      slot_nxt    = slot + 2'd1;
    end
  end

`ifdef FFT_VIEWER_AUTOSCAN_EN
  localparam int AW = $clog2(AUTOSCAN_PERIOD + 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTOSCAN_PERIOD - 1);

  logic [AW-1:0] auto_cnt;

  assign auto_fire = (state == ST_SHOW) && (btn_step == 2'b00) && (auto_cnt == AUTO_LAST);

  always_ff @(posedge Clk) begin
    if (Reset || state != ST_SHOW || btn_step != 2'b00 || auto_fire) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end
`else
  assign auto_fire = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_OFF;
      Inspect     <= 8'd0;
      lat_cnt     <= 3'd0;
      disp        <= 16'd0;
      refresh_cnt <= 16'd0;
      slot        <= 2'd0;
      Anode       <= 4'b1111;
      Segments    <= 7'b1111111;
      Dp          <= 1'b1;
      Valid       <= 1'b0;
    end else if (!ActivateSSD) begin
      // any outstanding read is dropped; disp keeps the last good capture
      state       <= ST_OFF;
      lat_cnt     <= 3'd0;
      refresh_cnt <= 16'd0;
      slot        <= 2'd0;
      Anode       <= 4'b1111;
      Segments    <= 7'b1111111;
      Dp          <= 1'b1;
      Valid       <= 1'b0;
    end else begin
      refresh_cnt <= refresh_nxt;
      slot        <= slot_nxt;
      Anode       <= ~(4'b0001 << slot_nxt);
      Segments    <= hex7(disp_nxt[{slot_nxt, 2'b00} +: 4]);
      Dp          <= ~(~Ready && (slot_nxt == 2'd0));
      case (state)
        ST_OFF: begin
          state   <= ST_REQ;
          lat_cnt <= LAT_LOAD;
        end
        ST_REQ: begin
          if (do_step) begin
            Inspect <= step_addr;
            lat_cnt <= LAT_LOAD;
          end else if (capture) begin
            disp  <= Result;
            Valid <= 1'b1;
            state <= ST_SHOW;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        ST_SHOW: begin
          if (do_step || auto_fire) begin
            Inspect <= do_step ? step_addr : Inspect + 8'd1;
            lat_cnt <= LAT_LOAD;
            Valid   <= 1'b0;
            state   <= ST_REQ;
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule
